// File: rtl/sum_regfile_pkg.sv
// Shared definitions for the register-file sum datapath and its sequencer.
package sum_regfile_pkg;

  localparam int DW_DEF = 8;

  // Register map: R0 reads as zero, R1 holds i, R2 holds the sum, R3 holds 1.
  localparam logic [1:0] REG_ZERO = 2'd0;
  localparam logic [1:0] REG_I    = 2'd1;
  localparam logic [1:0] REG_SUM  = 2'd2;
  localparam logic [1:0] REG_ONE  = 2'd3;

  typedef enum logic [3:0] {
    IDLE   = 4'd0,
    INIT_I = 4'd1,
    INIT_S = 4'd2,
    INIT_K = 4'd3,
    CMP    = 4'd4,
    ADD    = 4'd5,
    INC    = 4'd6,
    OUT    = 4'd7,
    DONE   = 4'd8
  } state_t;

endpackage

// File: rtl/sum_regfile_seq_ctrl.sv
// Sequencer that steps the register-file datapath through sum(1..N) for a
// run-time N, clamped to MAX_N so the loop always terminates.
module sum_regfile_seq_ctrl
  import sum_regfile_pkg::*;
#(
  parameter int DW    = DW_DEF,
  parameter int MAX_N = 22
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          start,
  input  logic [DW-1:0] n_limit,
  input  logic          iLeN,
  output logic          busy,
  output logic          done,
  output logic          R1SrcSel,
  output logic [1:0]    r_addr_0,
  output logic [1:0]    r_addr_1,
  output logic          w_en,
  output logic [1:0]    w_addr,
  output logic [DW-1:0] imm,
  output logic [DW-1:0] lim,
  output logic          OutLoad
);

  localparam logic [DW-1:0] MAX_N_V = MAX_N[DW-1:0];

  state_t state;
  state_t state_nxt;

  // Saturate the requested N so i can never wrap past the compare limit.
  function automatic logic [DW-1:0] clamp_n(input logic [DW-1:0] n);
    clamp_n = (n > MAX_N_V) ? MAX_N_V : n;
  endfunction

  // State register and the limit latched when a run is accepted.
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      lim   <= '0;
    end else begin
      state <= state_nxt;
      if (state == IDLE && start) begin
        lim <= clamp_n(n_limit);
      end
    end
  end

  // Next-state logic; unused encodings fall back to IDLE.
  always_comb begin
    state_nxt = IDLE;
    case (state)
      IDLE:    state_nxt = start ? INIT_I : IDLE;
      INIT_I:  state_nxt = INIT_S;
      INIT_S:  state_nxt = INIT_K;
      INIT_K:  state_nxt = CMP;
      CMP:     state_nxt = iLeN ? ADD : OUT;
      ADD:     state_nxt = INC;
      INC:     state_nxt = CMP;
      OUT:     state_nxt = DONE;
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Micro-op decode: every control line is a pure function of the state.
  always_comb begin
    busy     = 1'b1;
    done     = 1'b0;
    R1SrcSel = 1'b0;
    r_addr_0 = REG_ZERO;
    r_addr_1 = REG_ZERO;
    w_en     = 1'b0;
    w_addr   = REG_ZERO;
    imm      = '0;
    OutLoad  = 1'b0;
    case (state)
      IDLE: begin
        busy = 1'b0;
      end
      INIT_I: begin
        w_en     = 1'b1;
        w_addr   = REG_I;
        R1SrcSel = 1'b1;
        imm      = DW'(1);
      end
      INIT_S: begin
        w_en     = 1'b1;
        w_addr   = REG_SUM;
        R1SrcSel = 1'b1;
      end
      INIT_K: begin
        w_en     = 1'b1;
        w_addr   = REG_ONE;
        R1SrcSel = 1'b1;
        imm      = DW'(1);
      end
      CMP: begin
        r_addr_0 = REG_I;
      end
      ADD: begin
        r_addr_0 = REG_SUM;
        r_addr_1 = REG_I;
        w_en     = 1'b1;
        w_addr   = REG_SUM;
      end
      INC: begin
        r_addr_0 = REG_I;
        r_addr_1 = REG_ONE;
        w_en     = 1'b1;
        w_addr   = REG_I;
      end
      OUT: begin
        r_addr_0 = REG_SUM;
        OutLoad  = 1'b1;
      end
      DONE: begin
        done = 1'b1;
      end
      default: begin
        busy = 1'b0;
      end
    endcase
  end

endmodule

// File: doc/sum_regfile_seq_ctrl.md
Name: sum_regfile_seq_ctrl

Overview:
- Handshaked sequencer for the 4-entry register-file sum datapath. Computes sum(1..N) with a run-time N instead of a fixed limit of 10.
- Accepts a start pulse and latches N. Steps the datapath through init, compare, add and increment micro-ops by driving the regfile read/write addresses, the write-data source select and the output load. Reports busy and done.
- Sits between a host/top FSM and the datapath. The datapath returns iLeN, which is (regfile read port 0 <= lim).

Parameters:
- DW, 8, data width of imm, lim and n_limit.
- MAX_N, 22, saturation ceiling for n_limit. 22 is the largest N whose sum, 253, fits in 8 bits.

Ports:
- clk  in  1  system clock, rising edge
- rst  in  1  synchronous, active-high reset
- start  in  1  request pulse; sampled only in IDLE
- n_limit  in  DW  requested N; sampled with start
- iLeN  in  1  datapath compare flag: rdata0 <= lim
- busy  out  1  high from the cycle after start is accepted through the DONE cycle
- done  out  1  one-cycle pulse; the result is valid on the datapath out from this cycle
- R1SrcSel  out  1  1 = regfile write data is imm; 0 = ALU sum rdata0+rdata1
- r_addr_0  out  2  regfile read address 0
- r_addr_1  out  2  regfile read address 1
- w_en  out  1  regfile write enable
- w_addr  out  2  regfile write address
- imm  out  DW  immediate write value
- lim  out  DW  registered, clamped N, fed to the datapath comparator
- OutLoad  out  1  loads the datapath output register from rdata0

Behaviour:
- Reset and clocking: one clock, clk; rst is synchronous active-high. Reset forces state IDLE and lim=0. All outputs are 0 in the cycle after reset is sampled, and rst overrides everything else.
- Register map: R0 reads as 0 and is never written; R1 = i; R2 = sum; R3 = constant 1.
- Outputs are a combinational decode of the state register, except lim. Any signal not listed for a state is 0.
- IDLE: busy=0. If start=1, set lim <= min(n_limit, MAX_N) and go to INIT_I.
- INIT_I: w_en=1, w_addr=1, R1SrcSel=1, imm=1. Go to INIT_S.
- INIT_S: w_en=1, w_addr=2, R1SrcSel=1, imm=0. Go to INIT_K.
- INIT_K: w_en=1, w_addr=3, R1SrcSel=1, imm=1. Go to CMP.
- CMP: r_addr_0=1. If iLeN, go to ADD; otherwise go to OUT.
- ADD: r_addr_0=2, r_addr_1=1, w_en=1, w_addr=2. Go to INC.
- INC: r_addr_0=1, r_addr_1=3, w_en=1, w_addr=1. Go to CMP.
- OUT: r_addr_0=2, OutLoad=1. Go to DONE.
- DONE: done=1, busy=1. Go to IDLE unconditionally; start is ignored in this cycle.
- Latency: number the cycle after the accepting edge as 1. Then done is high in cycle 3N+6, where N is the clamped value.
- start while busy: ignored; lim is unchanged.
- A new start is accepted in the first IDLE cycle after DONE.
- N=0: CMP fails on the first pass; the result is 0.
- Clamping makes the loop finite. i never exceeds MAX_N+1, so i cannot wrap.
- Sum arithmetic is mod 2^DW in the datapath. The controller does no arithmetic beyond the clamp compare.
- rst mid-operation: return to IDLE and cancel the run; no done is issued. Regfile contents are don't-care, since INIT rewrites them.
- Illegal state encodings recover to IDLE.

Decomposition:
- Shared package sum_regfile_pkg holds:
  - typedef enum state_t {IDLE, INIT_I, INIT_S, INIT_K, CMP, ADD, INC, OUT, DONE};
  - register index constants REG_ZERO=0, REG_I=1, REG_SUM=2, REG_ONE=3;
  - the DW default.
- The datapath and the top level import the same package.
- No sub-module: next-state and output decode are two always_comb blocks in one module, roughly 150 lines.

Test Plan:
- Environment: the bench pairs the controller with a behavioural regfile-plus-adder datapath model.
- start=1, n_limit=10 -> done high at cycle 36 after acceptance; out=55; busy high in cycles 1..36.
- start=1, n_limit=0 -> INIT_I, INIT_S, INIT_K, CMP, OUT, DONE; done at cycle 6; out=0.
- n_limit=200 with MAX_N=22 -> lim=22; out=253; done at cycle 72.
- Pulse start with n_limit=5 at cycle 4 of an N=10 run -> ignored; lim stays 10; out=55.
- Assert rst at cycle 12 of an N=10 run -> next cycle all outputs 0, busy=0, no done. Then start with N=3 -> out=6, done at cycle 15.
- Assert start in the DONE cycle -> not accepted. Start asserted the following cycle -> accepted; second run correct.
